// File: rtl/fetch_unit_if.sv
`default_nettype none
// fetch_unit_if: instruction-memory handshake plus the decode-facing fetch bundle.
// Rev 1.0
interface fetch_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_data;
  logic        Dstall;
  logic        should_branch;
  logic [15:0] branch_addr;
  logic [15:0] Finstr;
  logic [15:0] Fpc;
  logic        Fvalid;

  modport master (
    output imem_req, imem_addr, Finstr, Fpc, Fvalid,
    input  imem_rdy, imem_data, Dstall, should_branch, branch_addr
  );

  modport slave (
    input  imem_req, imem_addr, Finstr, Fpc, Fvalid,
    output imem_rdy, imem_data, Dstall, should_branch, branch_addr
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// fetch_unit: PC owner, one-word-at-a-time fetch with redirect squash and drain.
// Rev 1.0 -- define FETCH_PERF_EN to add fetch_count/squash_count outputs.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  wire logic    clk,
  input  wire logic    rst,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]  fetch_count,
  output logic [15:0]  squash_count
`endif
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_drain_addr;
  logic [15:0] r_hold_data;
  logic [15:0] r_hold_pc;
  logic [15:0] r_finstr;
  logic [15:0] r_fpc;
  logic        r_fvalid;
  logic        r_outstanding;

  logic        w_req;
  logic        w_resp;
  logic        w_accept;
  logic        w_free;

  // A redirect may only suppress a request that has not yet been presented.
  assign w_req = !rst && (((r_state == S_FETCH) && (!bus.should_branch || r_outstanding))
                          || (r_state == S_DRAIN));

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
  assign bus.Finstr    = r_finstr;
  assign bus.Fpc       = r_fpc;
  assign bus.Fvalid    = r_fvalid;

  assign w_resp   = w_req && bus.imem_rdy;
  assign w_accept = r_fvalid && !bus.Dstall;
  assign w_free   = !r_fvalid || !bus.Dstall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_FETCH;
      r_pc          <= RESET_PC;
      r_drain_addr  <= 16'h0000;
      r_hold_data   <= 16'h0000;
      r_hold_pc     <= 16'h0000;
      r_finstr      <= 16'h0000;
      r_fpc         <= 16'h0000;
      r_fvalid      <= 1'b0;
      r_outstanding <= 1'b0;
    end else begin
      r_outstanding <= w_req && !bus.imem_rdy;
      if (bus.should_branch) begin
        r_pc     <= bus.branch_addr;
        r_fvalid <= 1'b0;
        r_finstr <= 16'h0000;
        if (w_req && !bus.imem_rdy) begin
          r_state <= S_DRAIN;
          if (r_state == S_FETCH) begin
            r_drain_addr <= r_pc;
          end
        end else begin
          r_state <= S_WAIT;
        end
      end else begin
        if (w_accept) begin
          r_fvalid <= 1'b0;
          r_finstr <= 16'h0000;
        end
        case (r_state)
          S_FETCH: begin
            if (w_resp) begin
              r_pc <= r_pc + 16'h0001;
              if (w_free) begin
                r_finstr <= bus.imem_data;
                r_fpc    <= r_pc;
                r_fvalid <= 1'b1;
              end else begin
                r_hold_data <= bus.imem_data;
                r_hold_pc   <= r_pc;
                r_state     <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (!bus.Dstall) begin
              r_finstr <= r_hold_data;
              r_fpc    <= r_hold_pc;
              r_fvalid <= 1'b1;
              r_state  <= S_FETCH;
            end
          end
          S_DRAIN: begin
            if (bus.imem_rdy) begin
              r_state <= S_FETCH;
            end
          end
          S_WAIT: begin
            r_state <= S_FETCH;
          end
          default: begin
            r_state <= S_FETCH;
          end
        endcase
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] r_fetch_count;
  logic [15:0] r_squash_count;
  logic        w_squash;

  // One squash per cycle regardless of how many valid words die together.
  assign w_squash = (bus.should_branch && (r_fvalid || (r_state == S_HOLD) || w_resp))
                    || ((r_state == S_DRAIN) && bus.imem_rdy);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_count  <= 16'h0000;
      r_squash_count <= 16'h0000;
    end else begin
      if (w_accept && !bus.should_branch) begin
        r_fetch_count <= r_fetch_count + 16'h0001;
      end
      if (w_squash) begin
        r_squash_count <= r_squash_count + 16'h0001;
      end
    end
  end

  assign fetch_count  = r_fetch_count;
  assign squash_count = r_squash_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// tb_fetch_unit: directed scenarios plus randomized traffic against a program-order model.
// Rev 1.0
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic zero_wait = 1'b1;
  logic rand_lat  = 1'b0;
  logic lat_rdy   = 1'b0;
  int   lat_cnt   = 0;
  int   lat_L     = 1;

  fetch_unit_if bus();

  assign bus.imem_rdy  = bus.imem_req && (zero_wait || lat_rdy);
  assign bus.imem_data = bus.imem_rdy ? (bus.imem_addr + 16'h1000) : 16'hDEAD;

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count;
  logic [15:0] squash_count;
`endif

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count  (fetch_count),
    .squash_count (squash_count)
`endif
  );

  always #5 clk = ~clk;

  // Memory with configurable latency, and a request-stability monitor.
  initial begin
    logic        p_req;
    logic        p_rdy;
    logic [15:0] p_addr;
    p_req  = 1'b0;
    p_rdy  = 1'b0;
    p_addr = 16'h0000;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        lat_rdy = 1'b0;
        lat_cnt = 0;
      end else begin
        if (lat_rdy) begin
          lat_rdy = 1'b0;
          lat_cnt = 0;
        end
        if (!zero_wait && bus.imem_req) begin
          if (lat_cnt == 0 && rand_lat) lat_L = $urandom_range(1, 3);
          lat_cnt++;
          if (lat_cnt >= lat_L) lat_rdy = 1'b1;
        end else if (!bus.imem_req) begin
          lat_cnt = 0;
        end
      end
      #1;
      if (!rst && p_req && !p_rdy) begin
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== p_addr) begin
          failures++;
          $display("FAIL req_stable t=%0t req=%b addr=%h required req=1 addr=%h",
                   $time, bus.imem_req, bus.imem_addr, p_addr);
        end
      end
      p_req  = bus.imem_req && !rst;
      p_rdy  = bus.imem_rdy;
      p_addr = bus.imem_addr;
    end
  end

  task automatic do_reset(input logic sb, input logic [15:0] ba);
    @(negedge clk);
    rst = 1'b1;
    bus.should_branch = 1'b0;
    bus.Dstall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.should_branch = sb;
    bus.branch_addr = ba;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.Fvalid !== 1'b0 || bus.Finstr !== 16'h0000 || bus.Fpc !== 16'h0000) begin
      failures++;
      $display("FAIL reset_outputs got Fvalid=%b Finstr=%h Fpc=%h required 0/0000/0000",
               bus.Fvalid, bus.Finstr, bus.Fpc);
    end
    checks++;
    if (bus.imem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_req got=%b required=0", bus.imem_req);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin
      failures++;
      $display("FAIL first_req got req=%b addr=%h required 1/0000", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_stream();
    zero_wait = 1'b1;
    do_reset(1'b0, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.Fvalid !== 1'b1 || bus.Fpc !== 16'(i) || bus.Finstr !== 16'h1000 + 16'(i)) begin
        failures++;
        $display("FAIL stream[%0d] got v=%b pc=%h instr=%h required 1/%h/%h",
                 i, bus.Fvalid, bus.Fpc, bus.Finstr, 16'(i), 16'h1000 + 16'(i));
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 4; i < 6; i++) @(negedge clk);
    bus.Dstall = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      checks++;
      if (bus.Fvalid !== 1'b1 || bus.Fpc !== 16'h0005 || bus.Finstr !== 16'h1005) begin
        failures++;
        $display("FAIL stall_hold[%0d] got v=%b pc=%h instr=%h required 1/0005/1005",
                 j, bus.Fvalid, bus.Fpc, bus.Finstr);
      end
      if (j == 3) bus.Dstall = 1'b0;
      #1;
      checks++;
      if (bus.imem_req !== 1'b0) begin
        failures++;
        $display("FAIL hold_req[%0d] got=%b required=0", j, bus.imem_req);
      end
    end
    for (int k = 6; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (bus.Fvalid !== 1'b1 || bus.Fpc !== 16'(k) || bus.Finstr !== 16'h1000 + 16'(k)) begin
        failures++;
        $display("FAIL stall_release[%0d] got v=%b pc=%h instr=%h", k, bus.Fvalid, bus.Fpc, bus.Finstr);
      end
    end
  endtask

  task automatic test_redirect();
    zero_wait = 1'b1;
    do_reset(1'b0, 16'h0000);
    for (int i = 0; i < 4; i++) @(negedge clk);
    bus.should_branch = 1'b1;
    bus.branch_addr = 16'h0040;
    @(negedge clk);
    bus.should_branch = 1'b0;
    checks++;
    if (bus.Fvalid !== 1'b0 || bus.Finstr !== 16'h0000) begin
      failures++;
      $display("FAIL redirect_squash got v=%b instr=%h required 0/0000", bus.Fvalid, bus.Finstr);
    end
    #1;
    checks++;
    if (bus.imem_req !== 1'b0) begin
      failures++;
      $display("FAIL redirect_wait_req got=%b required=0", bus.imem_req);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0040) begin
      failures++;
      $display("FAIL redirect_req got req=%b addr=%h required 1/0040", bus.imem_req, bus.imem_addr);
    end
    @(negedge clk);
    checks++;
    if (bus.Fvalid !== 1'b1 || bus.Fpc !== 16'h0040 || bus.Finstr !== 16'h1040) begin
      failures++;
      $display("FAIL redirect_target got v=%b pc=%h instr=%h required 1/0040/1040",
               bus.Fvalid, bus.Fpc, bus.Finstr);
    end
  endtask

  task automatic test_drain();
    logic seen;
    zero_wait = 1'b0;
    rand_lat = 1'b0;
    lat_L = 3;
    do_reset(1'b1, 16'h0010);
    @(negedge clk);
    bus.should_branch = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0010) begin
      failures++;
      $display("FAIL drain_first_req got req=%b addr=%h required 1/0010", bus.imem_req, bus.imem_addr);
    end
    @(negedge clk);
    bus.should_branch = 1'b1;
    bus.branch_addr = 16'h0040;
    #1;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0010) begin
      failures++;
      $display("FAIL drain_keep_req got req=%b addr=%h required 1/0010", bus.imem_req, bus.imem_addr);
    end
    @(negedge clk);
    bus.should_branch = 1'b0;
    #1;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0010 || bus.Fvalid !== 1'b0) begin
      failures++;
      $display("FAIL drain_state got req=%b addr=%h v=%b required 1/0010/0",
               bus.imem_req, bus.imem_addr, bus.Fvalid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0040) begin
      failures++;
      $display("FAIL drain_next_req got req=%b addr=%h required 1/0040", bus.imem_req, bus.imem_addr);
    end
    seen = 1'b0;
    for (int t = 0; t < 12 && !seen; t++) begin
      @(negedge clk);
      if (bus.Fvalid) begin
        seen = 1'b1;
        checks++;
        if (bus.Fpc !== 16'h0040 || bus.Finstr !== 16'h1040) begin
          failures++;
          $display("FAIL drain_first_valid got pc=%h instr=%h required 0040/1040", bus.Fpc, bus.Finstr);
        end
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout got Fvalid=0 required a valid word within 12 cycles");
    end
  endtask

  task automatic test_wrap();
    logic seen;
    zero_wait = 1'b1;
    do_reset(1'b1, 16'hFFFF);
    @(negedge clk);
    bus.should_branch = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 8 && !seen; t++) begin
      @(negedge clk);
      if (bus.Fvalid) seen = 1'b1;
    end
    checks++;
    if (!seen || bus.Fpc !== 16'hFFFF || bus.Finstr !== 16'h0FFF) begin
      failures++;
      $display("FAIL wrap_ffff got v=%b pc=%h instr=%h required 1/ffff/0fff", bus.Fvalid, bus.Fpc, bus.Finstr);
    end
    @(negedge clk);
    checks++;
    if (bus.Fvalid !== 1'b1 || bus.Fpc !== 16'h0000 || bus.Finstr !== 16'h1000) begin
      failures++;
      $display("FAIL wrap_0000 got v=%b pc=%h instr=%h required 1/0000/1000", bus.Fvalid, bus.Fpc, bus.Finstr);
    end
  endtask

  task automatic test_reset_mid_stall();
    zero_wait = 1'b1;
    do_reset(1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) @(negedge clk);
    bus.Dstall = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.Fvalid !== 1'b0 || bus.Finstr !== 16'h0000 || bus.Fpc !== 16'h0000) begin
      failures++;
      $display("FAIL midreset_outputs got v=%b instr=%h pc=%h required 0/0000/0000",
               bus.Fvalid, bus.Finstr, bus.Fpc);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (fetch_count !== 16'h0000 || squash_count !== 16'h0000) begin
      failures++;
      $display("FAIL midreset_counters got fetch=%h squash=%h required 0/0", fetch_count, squash_count);
    end
`endif
    rst = 1'b0;
    bus.Dstall = 1'b0;
    #1;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin
      failures++;
      $display("FAIL midreset_restart got req=%b addr=%h required 1/0000", bus.imem_req, bus.imem_addr);
    end
    @(negedge clk);
    checks++;
    if (bus.Fvalid !== 1'b1 || bus.Fpc !== 16'h0000 || bus.Finstr !== 16'h1000) begin
      failures++;
      $display("FAIL midreset_first got v=%b pc=%h instr=%h required 1/0000/1000",
               bus.Fvalid, bus.Fpc, bus.Finstr);
    end
  endtask

  // Reference: decode must see the program-order stream from exp_pc, restarting at each redirect target.
  task automatic test_random();
    logic [15:0] exp_pc;
    logic        prev_sb, prev_dstall, prev_fv;
    logic [15:0] prev_fi, prev_fp;
    logic        new_sb, new_dstall;
    logic [15:0] new_ba;
    int          accepted;
    zero_wait = 1'b0;
    rand_lat = 1'b1;
    do_reset(1'b0, 16'h0000);
    exp_pc = 16'h0000;
    prev_sb = 1'b0; prev_dstall = 1'b0; prev_fv = 1'b0;
    prev_fi = 16'h0000; prev_fp = 16'h0000;
    accepted = 0;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      if (cyc == 600) zero_wait = 1'b1;
      @(negedge clk);
      if (!bus.Fvalid) begin
        checks++;
        if (bus.Finstr !== 16'h0000) begin
          failures++;
          $display("FAIL rnd_nop cyc=%0d got instr=%h required 0000", cyc, bus.Finstr);
        end
      end
      if (prev_sb) begin
        checks++;
        if (bus.Fvalid !== 1'b0) begin
          failures++;
          $display("FAIL rnd_squash cyc=%0d got Fvalid=%b required 0", cyc, bus.Fvalid);
        end
      end else if (prev_fv && prev_dstall) begin
        checks++;
        if (bus.Fvalid !== 1'b1 || bus.Finstr !== prev_fi || bus.Fpc !== prev_fp) begin
          failures++;
          $display("FAIL rnd_hold cyc=%0d got v=%b pc=%h instr=%h required 1/%h/%h",
                   cyc, bus.Fvalid, bus.Fpc, bus.Finstr, prev_fp, prev_fi);
        end
      end
      new_sb     = ($urandom_range(0, 11) == 0);
      new_dstall = ($urandom_range(0, 2) == 0);
      new_ba     = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      if (bus.Fvalid && !new_dstall && !new_sb) begin
        checks++;
        if (bus.Fpc !== exp_pc || bus.Finstr !== exp_pc + 16'h1000) begin
          failures++;
          $display("FAIL rnd_order cyc=%0d got pc=%h instr=%h required %h/%h",
                   cyc, bus.Fpc, bus.Finstr, exp_pc, exp_pc + 16'h1000);
        end
        exp_pc = bus.Fpc + 16'h0001;
        accepted++;
      end
      if (new_sb) exp_pc = new_ba;
      bus.should_branch = new_sb;
      bus.branch_addr   = new_ba;
      bus.Dstall        = new_dstall;
      prev_sb     = new_sb;
      prev_dstall = new_dstall;
      prev_fv     = bus.Fvalid;
      prev_fi     = bus.Finstr;
      prev_fp     = bus.Fpc;
    end
    @(negedge clk);
    bus.should_branch = 1'b0;
    bus.Dstall = 1'b0;
    checks++;
    if (accepted < 150) begin
      failures++;
      $display("FAIL rnd_progress got accepted=%0d required >=150", accepted);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (fetch_count !== 16'(accepted)) begin
      failures++;
      $display("FAIL rnd_fetch_count got=%h required=%h", fetch_count, 16'(accepted));
    end
`endif
  endtask

  initial begin
    bus.Dstall = 1'b0;
    bus.should_branch = 1'b0;
    bus.branch_addr = 16'h0000;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_drain();
    test_wrap();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
